// File: rtl/seg7_pio_avl.sv
// Avalon-MM seven-segment display driver with hex decode, blanking and blinking,
// plus debounced inputs with rising-edge capture and an interrupt. Optional macro: SEG7_DP_EN adds decimal points.
module seg7_pio_avl #(
    parameter int DIGITS       = 6,
    parameter int IN_WIDTH     = 9,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int BLINK_CYC    = 25000000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [2:0]          avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    output logic [31:0]         avs_readdata,
    output logic                irq,
    input  logic [IN_WIDTH-1:0] IN,
`ifdef SEG7_DP_EN
    output logic [8*DIGITS-1:0] HEX
`else
    output logic [7*DIGITS-1:0] HEX
`endif
);

`ifdef SEG7_DP_EN
    localparam int SEG_W = 8;
`else
    localparam int SEG_W = 7;
`endif
    localparam int DW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int BW = (BLINK_CYC > 2) ? $clog2(BLINK_CYC) : 1;

    localparam logic [2:0] A_DATA    = 3'd0;
    localparam logic [2:0] A_BLANK   = 3'd1;
    localparam logic [2:0] A_BLINK   = 3'd2;
    localparam logic [2:0] A_IN      = 3'd3;
    localparam logic [2:0] A_EDGE    = 3'd4;
    localparam logic [2:0] A_IRQMASK = 3'd5;
`ifdef SEG7_DP_EN
    localparam logic [2:0] A_DP      = 3'd6;
`endif

    logic [4*DIGITS-1:0]      data_reg;
    logic [DIGITS-1:0]        blank_reg;
    logic [DIGITS-1:0]        blink_reg;
    logic [IN_WIDTH-1:0]      irqmask_reg;
    logic [IN_WIDTH-1:0]      edge_reg;
`ifdef SEG7_DP_EN
    logic [DIGITS-1:0]        dp_reg;
`endif

    logic [IN_WIDTH-1:0]      sync1, sync2, sample_q, deb_q, deb_prev;
    logic [DW-1:0]            deb_cnt;
    logic                     deb_tick;
    logic [BW-1:0]            blink_cnt;
    logic                     phase_on;

    logic [IN_WIDTH-1:0]      edge_clr, edge_rise, agree;
    logic [31:0]              rd_mux;
    logic [SEG_W*DIGITS-1:0]  hex_next;
    logic                     unused_wdata;

    // Only the low bits of each write land in a register; the rest are don't-care.
    assign unused_wdata = ^avs_writedata;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0e;
        endcase
        return s;
    endfunction

    // Bus handshake: avs_write/avs_read are single-cycle strobes that are always
    // accepted (no waitrequest); read data appears the following cycle, else 0.
    assign deb_tick  = (deb_cnt == DW'(DEBOUNCE_CYC - 1));
    assign agree     = ~(sync2 ^ sample_q);
    assign edge_rise = deb_q & ~deb_prev;
    assign edge_clr  = (avs_write && avs_address == A_EDGE) ? avs_writedata[IN_WIDTH-1:0]
                                                            : '0;

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            A_DATA:    rd_mux[4*DIGITS-1:0] = data_reg;
            A_BLANK:   rd_mux[DIGITS-1:0]   = blank_reg;
            A_BLINK:   rd_mux[DIGITS-1:0]   = blink_reg;
            A_IN:      rd_mux[IN_WIDTH-1:0] = deb_q;
            A_EDGE:    rd_mux[IN_WIDTH-1:0] = edge_reg;
            A_IRQMASK: rd_mux[IN_WIDTH-1:0] = irqmask_reg;
`ifdef SEG7_DP_EN
            A_DP:      rd_mux[DIGITS-1:0]   = dp_reg;
`endif
            default:   rd_mux = '0;
        endcase
    end

    // Blanking outranks blinking, which outranks the hex decode; both darken the DP.
    always_comb begin
        hex_next = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (blank_reg[k] || (blink_reg[k] && !phase_on)) begin
                hex_next[SEG_W*k +: 7] = 7'h7f;
            end else begin
                hex_next[SEG_W*k +: 7] = seg_decode(data_reg[4*k +: 4]);
`ifdef SEG7_DP_EN
                hex_next[SEG_W*k + 7] = ~dp_reg[k];
`endif
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            data_reg     <= '0;
            blank_reg    <= '1;
            blink_reg    <= '0;
            irqmask_reg  <= '0;
            edge_reg     <= '0;
`ifdef SEG7_DP_EN
            dp_reg       <= '0;
`endif
            avs_readdata <= '0;
            irq          <= 1'b0;
            HEX          <= '1;
        end else begin
            if (avs_write) begin
                case (avs_address)
                    A_DATA:    data_reg    <= avs_writedata[4*DIGITS-1:0];
                    A_BLANK:   blank_reg   <= avs_writedata[DIGITS-1:0];
                    A_BLINK:   blink_reg   <= avs_writedata[DIGITS-1:0];
                    A_IRQMASK: irqmask_reg <= avs_writedata[IN_WIDTH-1:0];
`ifdef SEG7_DP_EN
                    A_DP:      dp_reg      <= avs_writedata[DIGITS-1:0];
`endif
                    default: ;
                endcase
            end
            // A same-cycle rising edge overrides the W1C clear.
            edge_reg     <= (edge_reg & ~edge_clr) | edge_rise;
            irq          <= |(edge_reg & irqmask_reg);
            avs_readdata <= avs_read ? rd_mux : '0;
            HEX          <= hex_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1     <= '0;
            sync2     <= '0;
            sample_q  <= '0;
            deb_q     <= '0;
            deb_prev  <= '0;
            deb_cnt   <= '0;
            blink_cnt <= '0;
            phase_on  <= 1'b1;
        end else begin
            sync1    <= IN;
            sync2    <= sync1;
            deb_prev <= deb_q;
            deb_cnt  <= deb_tick ? '0 : deb_cnt + 1'b1;
            // A bit follows the input only once two consecutive samples agree.
            if (deb_tick) begin
                sample_q <= sync2;
                deb_q    <= (deb_q & ~agree) | (sync2 & agree);
            end
            if (blink_cnt == BW'(BLINK_CYC - 1)) begin
                blink_cnt <= '0;
                phase_on  <= ~phase_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_pio_avl.sv
// Self-checking bench for seg7_pio_avl: decode table, exact write-to-HEX latency, blink phase,
// debounce/glitch rejection, edge capture with set-over-clear, irq masking, reset, and DP when SEG7_DP_EN is set.
module tb_seg7_pio_avl;

    localparam int DIGITS    = 6;
    localparam int IN_WIDTH  = 9;
    localparam int DEB_CYC   = 4;
    localparam int BLINK_CYC = 8;
`ifdef SEG7_DP_EN
    localparam int HEX_W = 8 * DIGITS;
`else
    localparam int HEX_W = 7 * DIGITS;
`endif

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic [2:0]          avs_address = '0;
    logic                avs_read = 1'b0;
    logic                avs_write = 1'b0;
    logic [31:0]         avs_writedata = '0;
    logic [31:0]         avs_readdata;
    logic                irq;
    logic [IN_WIDTH-1:0] in_bus = '0;
    logic [HEX_W-1:0]    HEX;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};

    typedef struct {
        logic [31:0]         data;
        logic [31:0]         blank;
        logic [7*DIGITS-1:0] hex;
    } vec_t;
    vec_t vecs [5];

    seg7_pio_avl #(
        .DIGITS(DIGITS), .IN_WIDTH(IN_WIDTH), .DEBOUNCE_CYC(DEB_CYC), .BLINK_CYC(BLINK_CYC)
    ) dut (
        .CLK(CLK), .RST(RST), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .irq(irq), .IN(in_bus), .HEX(HEX)
    );

    // Clock / reset / cycle bookkeeping
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= RST ? 0 : cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Driver tasks
    task automatic tick_n(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic do_reset();
        RST = 1'b1; avs_read = 1'b0; avs_write = 1'b0;
        tick_n(3);
        RST = 1'b0;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(posedge CLK); #1;
        avs_write = 1'b0; avs_writedata = '0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        @(posedge CLK); #1;
        d = avs_readdata; avs_read = 1'b0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model
    function automatic logic [7*DIGITS-1:0] hex7(input logic [HEX_W-1:0] h);
        logic [7*DIGITS-1:0] r;
`ifdef SEG7_DP_EN
        for (int k = 0; k < DIGITS; k++) r[7*k +: 7] = h[8*k +: 7];
`else
        r = h;
`endif
        return r;
    endfunction

    // HEX seen now reflects the blink phase one cycle back; the phase starts on and flips every BLINK_CYC cycles.
    function automatic bit phase_now();
        return (((cyc - 1) / BLINK_CYC) % 2) == 0;
    endfunction

    function automatic logic [7*DIGITS-1:0] model_hex(input logic [31:0] data, input logic [31:0] blank,
                                                      input logic [31:0] blink, input bit ph_on);
        logic [7*DIGITS-1:0] r;
        for (int k = 0; k < DIGITS; k++) begin
            if (blank[k] || (blink[k] && !ph_on)) r[7*k +: 7] = 7'h7f;
            else r[7*k +: 7] = seg_tab[(data >> (4*k)) % 16];
        end
        return r;
    endfunction

    initial begin
        logic [31:0] rd;
        logic [31:0] d, b, bl;
        logic [IN_WIDTH-1:0] m_in, m_edge, m_mask, v, c;
        int n_found;
        bit all_zero;

        vecs[0] = '{32'h0000_F80A, 32'h00, {7'h40, 7'h40, 7'h0e, 7'h00, 7'h40, 7'h08}};
        vecs[1] = '{32'h0012_3456, 32'h00, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}};
        vecs[2] = '{32'h0078_9ABC, 32'h05, {7'h78, 7'h00, 7'h10, 7'h7f, 7'h03, 7'h7f}};
        vecs[3] = '{32'h00FE_DCBA, 32'h20, {7'h7f, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08}};
        vecs[4] = '{32'hFFFF_FFFF, 32'h00, {6{7'h0e}}};

        // Reset and idle
        do_reset();
        tick_n(20);
        check("reset_hex", HEX, {HEX_W{1'b1}});
        check("reset_irq", irq, 0);
        check("idle_readdata", avs_readdata, 0);
        bus_read(3'd1, rd); check("reset_blank", rd, 32'h3F);
        bus_read(3'd0, rd); check("reset_data", rd, 0);
        bus_read(3'd4, rd); check("reset_edge", rd, 0);
        bus_read(3'd3, rd); check("reset_in", rd, 0);
        bus_read(3'd7, rd); check("undef_addr7", rd, 0);
        bus_write(3'd3, 32'h1FF);
        bus_read(3'd3, rd); check("in_ro", rd, 0);

        // Write-to-HEX latency
        bus_write(3'd1, 32'h0);
        tick_n(2);
        check("data0_hex", hex7(HEX), {6{7'h40}});
        bus_write(3'd0, 32'h0000_F80A);
        check("hex_lat_1cyc", hex7(HEX), {6{7'h40}});
        tick_n(1);
        check("hex_lat_2cyc", hex7(HEX), vecs[0].hex);

        // Decode table
        for (int i = 0; i < 5; i++) begin
            bus_write(3'd1, vecs[i].blank);
            bus_write(3'd0, vecs[i].data);
            tick_n(2);
            check($sformatf("table_hex[%0d]", i), hex7(HEX), vecs[i].hex);
        end
        bus_read(3'd0, rd); check("data_readback", rd, 32'h00FF_FFFF);

        // Blink on digit 0
        bus_write(3'd1, 32'h0);
        bus_write(3'd0, 32'h0000_F80A);
        bus_write(3'd2, 32'h01);
        tick_n(2);
        for (int i = 0; i < 40; i++) begin
            check($sformatf("blink_hex[%0d]", i), hex7(HEX),
                  model_hex(32'h0000_F80A, 32'h0, 32'h1, phase_now()));
            tick_n(1);
        end
        bus_read(3'd2, rd); check("blink_readback", rd, 32'h01);

        // Glitch rejection, debounce latency, edge and irq on IN[0]
        in_bus[0] = 1'b1;
        all_zero = 1'b1;
        for (int i = 0; i < 2; i++) begin bus_read(3'd3, rd); if (rd != 0) all_zero = 1'b0; end
        in_bus[0] = 1'b0;
        for (int i = 0; i < 12; i++) begin bus_read(3'd3, rd); if (rd != 0) all_zero = 1'b0; end
        check("glitch_rejected", all_zero, 1'b1);
        bus_read(3'd4, rd); check("glitch_no_edge", rd, 0);
        in_bus[0] = 1'b1;
        n_found = 0;
        for (int i = 1; i <= 3 * DEB_CYC + 4; i++) begin
            bus_read(3'd3, rd);
            if (rd == 32'h1) begin n_found = i; break; end
        end
        check("in_rise_seen", n_found != 0, 1'b1);
        check("in_rise_min_latency", n_found >= 3 + DEB_CYC, 1'b1);
        check("in_rise_max_latency", n_found <= 3 + 2 * DEB_CYC, 1'b1);
        tick_n(3);
        bus_read(3'd4, rd); check("edge_set", rd, 32'h1);
        check("irq_masked", irq, 0);
        bus_write(3'd5, 32'h1);
        tick_n(2);
        check("irq_unmasked", irq, 1);
        bus_write(3'd4, 32'h1);
        tick_n(2);
        bus_read(3'd4, rd); check("edge_w1c", rd, 0);
        check("irq_cleared", irq, 0);

        // Set-over-clear: locate the EDGE set cycle, then replay and clear on that cycle
        in_bus = '0;
        do_reset();
        tick_n(5);
        in_bus = 9'h002;
        n_found = 0;
        for (int i = 1; i <= 4 * DEB_CYC + 8; i++) begin
            bus_read(3'd4, rd);
            if (rd != 0) begin n_found = i; break; end
        end
        check("edge1_found", n_found >= 2, 1'b1);
        if (n_found >= 2) begin
            in_bus = '0;
            do_reset();
            tick_n(5);
            in_bus = 9'h002;
            tick_n(n_found - 2);
            bus_write(3'd4, 32'h3);
            tick_n(4);
            bus_read(3'd4, rd); check("edge_set_wins", rd, 32'h2);
            bus_write(3'd5, 32'h1);
            tick_n(3);
            check("irq_other_bit_masked", irq, 0);
        end

        // Randomized display and input rounds
        in_bus = '0;
        do_reset();
        m_in = '0; m_edge = '0; m_mask = '0;
        for (int r = 0; r < 8; r++) begin
            d  = $urandom;
            b  = 32'($urandom_range(0, 63));
            bl = 32'($urandom_range(0, 63));
            bus_write(3'd1, b);
            bus_write(3'd2, bl);
            bus_write(3'd0, d);
            tick_n(2);
            for (int i = 0; i < 12; i++) begin
                check($sformatf("rand_hex[%0d.%0d]", r, i), hex7(HEX), model_hex(d, b, bl, phase_now()));
                tick_n(1);
            end
        end
        for (int r = 0; r < 10; r++) begin
            v = IN_WIDTH'($urandom_range(0, (1 << IN_WIDTH) - 1));
            in_bus = v;
            tick_n(5 * DEB_CYC);
            m_edge = m_edge | (v & ~m_in);
            m_in = v;
            m_mask = IN_WIDTH'($urandom_range(0, (1 << IN_WIDTH) - 1));
            c = IN_WIDTH'($urandom_range(0, (1 << IN_WIDTH) - 1));
            bus_write(3'd5, 32'(m_mask));
            bus_write(3'd4, 32'(c));
            m_edge = m_edge & ~c;
            tick_n(2);
            bus_read(3'd3, rd); check($sformatf("rand_in[%0d]", r), rd, 64'(m_in));
            bus_read(3'd4, rd); check($sformatf("rand_edge[%0d]", r), rd, 64'(m_edge));
            check($sformatf("rand_irq[%0d]", r), irq, |(m_edge & m_mask));
        end

        // Reset in the middle of blinking and debouncing
        bus_write(3'd1, 32'h0);
        bus_write(3'd2, 32'h3F);
        bus_write(3'd5, 32'h1FF);
        in_bus = ~m_in;
        tick_n(DEB_CYC + 3);
        avs_read = 1'b1; avs_address = 3'd0;
        RST = 1'b1;
        tick_n(1);
        avs_read = 1'b0;
        check("midrst_hex", HEX, {HEX_W{1'b1}});
        check("midrst_irq", irq, 0);
        check("midrst_readdata", avs_readdata, 0);
        RST = 1'b0;
        bus_read(3'd1, rd); check("midrst_blank", rd, 32'h3F);
        bus_read(3'd3, rd); check("midrst_in", rd, 0);
        bus_read(3'd5, rd); check("midrst_mask", rd, 0);
        bus_read(3'd2, rd); check("midrst_blink", rd, 0);
        in_bus = '0;
        do_reset();

        // Decimal point register
`ifdef SEG7_DP_EN
        bus_write(3'd6, 32'h20);
        bus_write(3'd1, 32'h0);
        tick_n(2);
        check("dp_msb_lit", HEX[47], 0);
        for (int k = 0; k < DIGITS - 1; k++) check($sformatf("dp_dark[%0d]", k), HEX[8*k + 7], 1);
        bus_read(3'd6, rd); check("dp_readback", rd, 32'h20);
`else
        bus_write(3'd6, 32'hFF);
        bus_read(3'd6, rd); check("addr6_reads_zero", rd, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
